mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Parametrised, iterative multiply/divide unit with HI/LO result registers, serving the mult/multu/div/divu instructions of the multicycle CPU datapath.
- Sits beside the ALU. The control FSM pulses start and stalls until done. It then moves hi/lo into the register file through the write-data mux (mfhi/mflo).
- Generalises a fixed 32-bit ALU path to any operand width, with signed/unsigned modes, a busy/done handshake and divide-by-zero signalling.

Parameters:
- WIDTH, 32, operand width in bits. hi and lo are each WIDTH bits. Legal values are 4..64.
- CNT_W, $clog2(WIDTH+1), width of the internal iteration counter. Derived; not for override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse. Sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide. Sampled with start.
- sgn  in  1  1 = signed (mult/div), 0 = unsigned (multu/divu). Sampled with start.
- a  in  WIDTH  multiplicand / dividend. Sampled with start.
- b  in  WIDTH  multiplier / divisor. Sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when hi/lo are valid or an error is signalled.
- div_by_zero  out  1  one-cycle pulse, coincident with done, on a divide with b == 0.
- hi  out  WIDTH  multiply: upper product half; divide: remainder.
- lo  out  WIDTH  multiply: lower product half; divide: quotient.

Behaviour:
- Reset (reset low, asynchronous): state = IDLE; busy, done, div_by_zero = 0; hi = lo = 0; all internal registers cleared. Reset mid-operation aborts it silently: no done pulse, hi/lo = 0.
- State IDLE:
  - start = 1 latches op, sgn, operand magnitudes and result-sign flags.
  - If op = 1 and b == 0: go to ERR.
  - Otherwise: go to RUN with counter = WIDTH.
  - start = 0: remain in IDLE.
- State RUN: one iteration per cycle, counter decrements, busy = 1. Leave for FIX when counter reaches 0 (exactly WIDTH cycles).
  - Multiply: shift-add, radix 2, on unsigned magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring, radix 2, on magnitudes. Produces a WIDTH-bit quotient and a WIDTH-bit remainder.
- State FIX (1 cycle): apply signs, write hi/lo, pulse done, go to IDLE.
  - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: quotient negated if the signs differ (truncation toward zero). Remainder takes the sign of the dividend.
  - Special case MIN / -1: quotient = MIN (wraps), remainder = 0. No error is raised.
- State ERR (1 cycle): done = 1 and div_by_zero = 1; hi/lo unchanged; busy = 0; go to IDLE.
- Latency:
  - Normal: start accepted at edge N; busy high N+1..N+WIDTH+1; done high in cycle N+WIDTH+2, with hi/lo updated at the same edge.
  - Divide by zero: done in cycle N+1.
- Output timing:
  - busy is low in the done cycle.
  - start asserted in the done cycle is ignored. The next start is accepted the following cycle, in IDLE.
  - start while busy is ignored; latched operands are unaffected.
- hi/lo change only at FIX (or reset) and hold otherwise. Operand inputs may change freely after start is accepted.
- Unsigned mode treats the MSB as magnitude: no negation, and no MIN/-1 special case.

Decomposition:
- Shared package mdu_pkg:
  - op encodings (MDU_MUL = 1'b0, MDU_DIV = 1'b1);
  - state enum (IDLE, RUN, FIX, ERR).
- One sub-module is natural: mdu_sign_adj, combinational.
  - Computes conditional two's-complement negate and absolute value for a given width (parameter W).
  - Instantiated for operand magnitudes (W = WIDTH) and for the product fix-up (W = 2*WIDTH).

Test Plan (WIDTH = 32):
- Signed mult: a = 7, b = 0xFFFFFFFD (-3), sgn = 1 -> 34 cycles after start: done = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy was high for exactly 33 cycles.
- Unsigned mult: a = b = 0xFFFFFFFF, sgn = 0 -> hi = 0xFFFFFFFE, lo = 0x00000001.
- Signed div: a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). The same operands with sgn = 0 give lo = 0x7FFFFFFC, hi = 0x00000001.
- Overflow case: a = 0x80000000, b = 0xFFFFFFFF, signed div -> lo = 0x80000000, hi = 0, div_by_zero = 0.
- Divide by zero: preload hi/lo via a mult, then div with b = 0 -> done and div_by_zero high for exactly 1 cycle, one cycle after start; hi/lo unchanged.
- Control:
  - Start pulsed mid-RUN -> ignored, and the result matches the first operands.
  - reset low mid-RUN -> busy = 0, hi = lo = 0, no done pulse.
  - Next start after reset runs normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings and controller state type.
package mdu_pkg;

  localparam logic MDU_MUL = 1'b0;
  localparam logic MDU_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    ERR
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_adj.sv
// Combinational two's-complement helper: conditional negate (i_neg) or,
// with i_abs set, absolute value of a signed input.
module mdu_sign_adj #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  input  logic         i_abs,
  output logic [W-1:0] o_res
);

  logic w_flip;

  assign w_flip = i_abs ? i_val[W-1] : i_neg;
  assign o_res  = w_flip ? -i_val : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Works on magnitudes for WIDTH cycles, then applies signs in one fix-up cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_e         r_state;
  mdu_state_e         w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_done;
  logic [WIDTH-1:0]   r_acc_hi;
  logic [WIDTH-1:0]   r_acc_lo;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_trial;
  logic               w_accept;

  // r_done blocks a start in the done cycle itself.
  assign w_accept    = (r_state == IDLE) && start && !r_done;
  assign busy        = (r_state == RUN) || (r_state == FIX);
  assign done        = r_done || (r_state == ERR);
  assign div_by_zero = (r_state == ERR);
  assign hi          = r_hi;
  assign lo          = r_lo;

  mdu_sign_adj #(.W(WIDTH)) u_abs_a (
    .i_val(a), .i_neg(1'b0), .i_abs(sgn), .o_res(w_abs_a)
  );
  mdu_sign_adj #(.W(WIDTH)) u_abs_b (
    .i_val(b), .i_neg(1'b0), .i_abs(sgn), .o_res(w_abs_b)
  );
  mdu_sign_adj #(.W(2*WIDTH)) u_prod_fix (
    .i_val({r_acc_hi, r_acc_lo}), .i_neg(r_neg_q), .i_abs(1'b0), .o_res(w_prod_fix)
  );
  mdu_sign_adj #(.W(WIDTH)) u_quo_fix (
    .i_val(r_acc_lo), .i_neg(r_neg_q), .i_abs(1'b0), .o_res(w_quo_fix)
  );
  mdu_sign_adj #(.W(WIDTH)) u_rem_fix (
    .i_val(r_acc_hi), .i_neg(r_neg_r), .i_abs(1'b0), .o_res(w_rem_fix)
  );

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  assign w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
  assign w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opnd};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = ((op == MDU_DIV) && (b == '0)) ? ERR : RUN;
        end
      end
      RUN: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = FIX;
        end
      end
      FIX:     w_state_next = IDLE;
      ERR:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op     <= op;
            r_neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= sgn & a[WIDTH-1];
            r_cnt    <= CNT_W'(WIDTH);
            r_acc_hi <= '0;
            r_acc_lo <= (op == MDU_DIV) ? w_abs_a : w_abs_b;
            r_opnd   <= (op == MDU_DIV) ? w_abs_b : w_abs_a;
          end
        end
        RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_op == MDU_MUL) begin
            {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[WIDTH-1:1]};
          end else if (!w_div_trial[WIDTH]) begin
            r_acc_hi <= w_div_trial[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_acc_hi <= w_div_shift[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          r_done <= 1'b1;
          if (r_op == MDU_MUL) begin
            {r_hi, r_lo} <= w_prod_fix;
          end else begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
